// File: rtl/base10_alu_pkg.sv
// Shared types and constants for the base-10 ALU issue stage.
// Opcodes, FSM states and the command FIFO entry layout.
package base10_alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_MUL = 4'd2,
        OP_DIV = 4'd3,
        OP_AND = 4'd4,
        OP_OR  = 4'd5,
        OP_XOR = 4'd6,
        OP_SHL = 4'd7,
        OP_SHR = 4'd8
    } alu_op_e;

    localparam logic [3:0] OP_LAST = 4'(OP_SHR);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } issue_state_e;

    localparam logic [31:0] TIMEOUT_RESULT = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } cmd_t;

endpackage

// File: rtl/base10_alu_issue_if.sv
// Command, ALU and response channels of the issue stage.
// master = issue stage, slave = its environment.
interface base10_alu_issue_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;

    logic        alu_enable;
    logic [3:0]  alu_operation;
    logic [31:0] alu_operand_a;
    logic [31:0] alu_operand_b;
    logic [31:0] alu_result;
    logic        alu_done;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_op;
    logic [3:0]  rsp_cycles;
    logic        rsp_error;

    modport master (
        input  cmd_valid, cmd_op, cmd_a, cmd_b,
        input  alu_result, alu_done,
        input  rsp_ready,
        output cmd_ready,
        output alu_enable, alu_operation,
        output alu_operand_a, alu_operand_b,
        output rsp_valid, rsp_result, rsp_op,
        output rsp_cycles, rsp_error
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_a, cmd_b,
        output alu_result, alu_done,
        output rsp_ready,
        input  cmd_ready,
        input  alu_enable, alu_operation,
        input  alu_operand_a, alu_operand_b,
        input  rsp_valid, rsp_result, rsp_op,
        input  rsp_cycles, rsp_error
    );

endinterface

// File: rtl/base10_cmd_fifo.sv
// Synchronous FIFO holding pending ALU commands.
// Pointers carry an extra wrap bit to tell full from empty.
module base10_cmd_fifo #(
    parameter int WIDTH = 68,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    // Advance pointers on accepted push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    // Pointer registers; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only read once pushed.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/base10_alu_issue.sv
// Issue stage for the base-10 ALU: queues commands, runs the
// enable/done handshake one at a time and returns tagged responses.
module base10_alu_issue #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic               clk,
    input  logic               reset,
    base10_alu_issue_if.master bus,
    output logic               busy
);

    import base10_alu_pkg::*;

    localparam logic [3:0] TO_VAL  = TIMEOUT[3:0];
    localparam logic [3:0] TO_LAST = TO_VAL - 4'd1;

    issue_state_e state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         en_q, en_d;
    logic [3:0]   op_q, op_d;
    logic [31:0]  a_q, a_d;
    logic [31:0]  b_q, b_d;
    logic [31:0]  res_q, res_d;
    logic [3:0]   rop_q, rop_d;
    logic [3:0]   cyc_q, cyc_d;
    logic         err_q, err_d;

    cmd_t         push_cmd;
    cmd_t         head;
    logic         fifo_full;
    logic         fifo_empty;
    logic         pop;
    logic         launch;

    assign push_cmd = '{op: bus.cmd_op, a: bus.cmd_a, b: bus.cmd_b};

    base10_cmd_fifo #(
        .WIDTH ($bits(cmd_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (bus.cmd_valid),
        .wdata (push_cmd),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.cmd_ready     = !fifo_full;
    assign bus.alu_enable    = en_q;
    assign bus.alu_operation = op_q;
    assign bus.alu_operand_a = a_q;
    assign bus.alu_operand_b = b_q;
    assign bus.rsp_valid     = (state_q == ST_RESP);
    assign bus.rsp_result    = res_q;
    assign bus.rsp_op        = rop_q;
    assign bus.rsp_cycles    = cyc_q;
    assign bus.rsp_error     = err_q;
    assign busy = !fifo_empty || (state_q != ST_IDLE);

    // Next state, ALU drive and response capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        en_d    = en_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        rop_d   = rop_q;
        cyc_d   = cyc_q;
        err_d   = err_q;
        launch  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) launch = 1'b1;
            end
            ST_ISSUE: begin
                if (bus.alu_done) begin
                    res_d   = bus.alu_result;
                    cyc_d   = cnt_q;
                    err_d   = 1'b0;
                    en_d    = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_q == TO_LAST) begin
                    res_d   = TIMEOUT_RESULT;
                    cyc_d   = TO_VAL;
                    err_d   = 1'b1;
                    en_d    = 1'b0;
                    cnt_d   = TO_VAL;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_RESP: begin
                en_d = 1'b0;
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                    if (!fifo_empty) launch = 1'b1;
                end
            end
            default: begin
                en_d    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        // Illegal opcodes skip the ALU and answer directly.
        pop = launch;
        if (launch) begin
            rop_d = head.op;
            if (head.op <= OP_LAST) begin
                op_d    = head.op;
                a_d     = head.a;
                b_d     = head.b;
                en_d    = 1'b1;
                cnt_d   = '0;
                state_d = ST_ISSUE;
            end else begin
                res_d   = '0;
                cyc_d   = '0;
                err_d   = 1'b1;
                en_d    = 1'b0;
                state_d = ST_RESP;
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            rop_q   <= '0;
            cyc_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            rop_q   <= rop_d;
            cyc_q   <= cyc_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_base10_alu_issue.sv
// Directed bench for base10_alu_issue with a level-protocol ALU stub.
// Expected results and cycle counts are hand-computed per vector.
module tb_base10_alu_issue;

    logic clk = 1'b0;
    logic reset;
    logic busy;
    logic hang;
    logic en_seen;
    logic alu_done_r = 1'b0;
    logic [31:0] alu_result_r = 32'd0;
    int k = 0;
    int total = 0;
    int bad = 0;
    int n;

    base10_alu_issue_if bus ();

    base10_alu_issue #(
        .FIFO_DEPTH (4),
        .TIMEOUT    (15)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    assign bus.alu_done   = alu_done_r;
    assign bus.alu_result = alu_result_r;

    function automatic int lat(input logic [3:0] op, input logic [31:0] b);
        case (op)
            4'd4, 4'd5: lat = 2;
            4'd2:       lat = 4;
            4'd3:       lat = (b == 10 || b == 100 || b == 0) ? 3 : 4;
            default:    lat = 3;
        endcase
    endfunction

    function automatic logic [31:0] calc(input logic [3:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
        case (op)
            4'd0: calc = a + b;
            4'd1: calc = a - b;
            4'd2: calc = a * b;
            4'd3: calc = (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd4: calc = a & b;
            4'd5: calc = a | b;
            4'd6: calc = a ^ b;
            4'd7: calc = a * 10;
            4'd8: calc = a / 10;
            default: calc = 32'd0;
        endcase
    endfunction

    // ALU stub: done rises after lat() enabled cycles, clears when enable drops.
    always @(posedge clk) begin
        if (!bus.alu_enable || hang) begin
            k <= 0;
            alu_done_r <= 1'b0;
        end else begin
            k <= k + 1;
            if (k + 1 == lat(bus.alu_operation, bus.alu_operand_b)) begin
                alu_done_r <= 1'b1;
                alu_result_r <= calc(bus.alu_operation,
                                     bus.alu_operand_a,
                                     bus.alu_operand_b);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b);
        int w;
        w = 0;
        while (!bus.cmd_ready && w < 50) begin
            step();
            w++;
        end
        chk("send_rdy", 32'(bus.cmd_ready), 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op = op;
        bus.cmd_a = a;
        bus.cmd_b = b;
        step();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int budget, output int cnt);
        cnt = 0;
        en_seen = 1'b0;
        do begin
            step();
            cnt++;
            if (bus.alu_enable) en_seen = 1'b1;
        end while (!bus.rsp_valid && cnt < budget);
        chk("rsp_seen", 32'(bus.rsp_valid), 1);
    endtask

    task automatic expect_rsp(input logic [3:0] op, input logic [31:0] res,
                              input logic [3:0] cyc, input logic err);
        chk("rsp_op", 32'(bus.rsp_op), 32'(op));
        chk("rsp_result", bus.rsp_result, res);
        chk("rsp_cycles", 32'(bus.rsp_cycles), 32'(cyc));
        chk("rsp_error", 32'(bus.rsp_error), 32'(err));
    endtask

    logic [3:0]  q_op  [5] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd6};
    logic [31:0] q_a   [5] = '{32'd1, 32'd9, 32'd3, 32'd5, 32'd6};
    logic [31:0] q_b   [5] = '{32'd1, 32'd4, 32'd3, 32'd2, 32'd3};
    logic [31:0] q_res [5] = '{32'd2, 32'd5, 32'd9, 32'd7, 32'd5};
    logic [3:0]  q_cyc [5] = '{4'd3, 4'd3, 4'd4, 4'd2, 4'd3};

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic stray;
        reset = 1'b0;
        hang = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op = '0;
        bus.cmd_a = '0;
        bus.cmd_b = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) step();
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 1);
        chk("rst_alu_en", 32'(bus.alu_enable), 0);
        chk("rst_alu_op", 32'(bus.alu_operation), 0);
        chk("rst_alu_a", bus.alu_operand_a, 0);
        chk("rst_alu_b", bus.alu_operand_b, 0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        expect_rsp(4'd0, 32'd0, 4'd0, 1'b0);
        chk("rst_busy", 32'(busy), 0);
        reset = 1'b1;

        // Single ADD with exact latency.
        bus.rsp_ready = 1'b1;
        send(4'd0, 32'd25, 32'd17);
        wait_rsp(20, n);
        chk("add_latency", n, 5);
        expect_rsp(4'd0, 32'd42, 4'd3, 1'b0);
        chk("add_en_off", 32'(bus.alu_enable), 0);
        step();
        chk("add_rsp_clr", 32'(bus.rsp_valid), 0);
        chk("add_idle_busy", 32'(busy), 0);

        // DIV fast path, divide by zero passthrough, MUL and AND.
        send(4'd3, 32'd1000, 32'd10);
        wait_rsp(20, n);
        expect_rsp(4'd3, 32'd100, 4'd3, 1'b0);
        send(4'd3, 32'd7, 32'd0);
        wait_rsp(20, n);
        expect_rsp(4'd3, 32'hFFFF_FFFF, 4'd3, 1'b0);
        send(4'd2, 32'd12, 32'd34);
        wait_rsp(20, n);
        expect_rsp(4'd2, 32'd408, 4'd4, 1'b0);
        send(4'd4, 32'hF0, 32'h3C);
        wait_rsp(20, n);
        expect_rsp(4'd4, 32'h30, 4'd2, 1'b0);
        step();

        // Queue fill with responses held back, then drain in order.
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(q_op[i], q_a[i], q_b[i]);
        chk("full_ready", 32'(bus.cmd_ready), 0);
        chk("full_busy", 32'(busy), 1);
        wait_rsp(20, n);
        expect_rsp(q_op[0], q_res[0], q_cyc[0], 1'b0);
        repeat (3) step();
        chk("hold_valid", 32'(bus.rsp_valid), 1);
        chk("hold_result", bus.rsp_result, q_res[0]);
        chk("hold_ready", 32'(bus.cmd_ready), 0);
        bus.rsp_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            wait_rsp(20, n);
            chk("q_interval", n, 32'(q_cyc[i]) + 2);
            expect_rsp(q_op[i], q_res[i], q_cyc[i], 1'b0);
            chk("q_en_low", 32'(bus.alu_enable), 0);
            if (i == 1) chk("q_slot_open", 32'(bus.cmd_ready), 1);
        end
        step();
        chk("q_drained_busy", 32'(busy), 0);

        // Illegal opcode never reaches the ALU.
        send(4'd12, 32'd5, 32'd5);
        wait_rsp(10, n);
        chk("ill_latency", n, 1);
        expect_rsp(4'd12, 32'd0, 4'd0, 1'b1);
        chk("ill_en_seen", 32'(en_seen), 0);
        step();

        // Hung ALU times out.
        hang = 1'b1;
        send(4'd0, 32'd1, 32'd2);
        wait_rsp(40, n);
        chk("to_latency", n, 16);
        expect_rsp(4'd0, 32'hFFFF_FFFF, 4'd15, 1'b1);
        chk("to_en_off", 32'(bus.alu_enable), 0);
        hang = 1'b0;
        step();

        // Reset in the middle of a MUL.
        send(4'd2, 32'd6, 32'd7);
        repeat (2) step();
        chk("mr_en_on", 32'(bus.alu_enable), 1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("mr_en", 32'(bus.alu_enable), 0);
        chk("mr_op", 32'(bus.alu_operation), 0);
        chk("mr_a", bus.alu_operand_a, 0);
        chk("mr_valid", 32'(bus.rsp_valid), 0);
        chk("mr_ready", 32'(bus.cmd_ready), 1);
        chk("mr_busy", 32'(busy), 0);
        expect_rsp(4'd0, 32'd0, 4'd0, 1'b0);
        stray = 1'b0;
        repeat (8) begin
            step();
            if (bus.rsp_valid || bus.alu_enable) stray = 1'b1;
        end
        chk("mr_dropped", 32'(stray), 0);
        send(4'd0, 32'd40, 32'd2);
        wait_rsp(20, n);
        chk("mr_next_latency", n, 5);
        expect_rsp(4'd0, 32'd42, 4'd3, 1'b0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
